// File: rtl/seq_signed_div.sv
// Multi-cycle signed divider: restoring division on magnitudes, one quotient bit per clock,
// followed by a sign-fixup cycle. Latency is WIDTH+2 edges from accepted start to done.
`timescale 1ns/1ps
module seq_signed_div #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

    state_e           r_state, w_state_nxt;
    logic [CntW-1:0]  r_cnt, w_cnt_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [WIDTH-1:0] r_quot, w_quot_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic             r_dz, w_dz_nxt;
    logic             r_ov, w_ov_nxt;

    // Working registers captured on an accepted start.
    logic [WIDTH-1:0] r_pr, w_pr_nxt;     // partial remainder magnitude
    logic [WIDTH-1:0] r_dvd, w_dvd_nxt;   // dividend magnitude, becomes quotient magnitude
    logic [WIDTH:0]   r_dvs, w_dvs_nxt;   // divisor magnitude, one extra bit for -2^(WIDTH-1)
    logic [WIDTH-1:0] r_a, w_a_nxt;       // raw dividend, returned as remainder on divide-by-zero
    logic             r_sa, w_sa_nxt;
    logic             r_sb, w_sb_nxt;
    logic             r_dz_c, w_dz_c_nxt;
    logic             r_ov_c, w_ov_c_nxt;

    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH:0]   w_dvs_ext;
    logic [WIDTH:0]   w_dvs_abs;
    logic [WIDTH:0]   w_shifted;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_q_signed;
    logic [WIDTH-1:0] w_r_signed;
    logic             w_last;

    // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), still representable as unsigned WIDTH bits.
    assign w_dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_dvs_ext = {divisor[WIDTH-1], divisor};
    assign w_dvs_abs = divisor[WIDTH-1] ? -w_dvs_ext : w_dvs_ext;

    // The kept difference is always below the divisor, so WIDTH bits hold it exactly.
    assign w_shifted = {r_pr, r_dvd[WIDTH-1]};
    assign w_ge      = (w_shifted >= r_dvs);
    assign w_diff    = w_shifted[WIDTH-1:0] - r_dvs[WIDTH-1:0];

    assign w_q_signed = (r_sa ^ r_sb) ? -r_dvd : r_dvd;
    assign w_r_signed = r_sa ? -r_pr : r_pr;
    assign w_last     = (r_cnt == CntW'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_quot_nxt  = r_quot;
        w_rem_nxt   = r_rem;
        w_dz_nxt    = r_dz;
        w_ov_nxt    = r_ov;
        w_pr_nxt    = r_pr;
        w_dvd_nxt   = r_dvd;
        w_dvs_nxt   = r_dvs;
        w_a_nxt     = r_a;
        w_sa_nxt    = r_sa;
        w_sb_nxt    = r_sb;
        w_dz_c_nxt  = r_dz_c;
        w_ov_c_nxt  = r_ov_c;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_pr_nxt    = '0;
                    w_dvd_nxt   = w_dvd_abs;
                    w_dvs_nxt   = w_dvs_abs;
                    w_a_nxt     = dividend;
                    w_sa_nxt    = dividend[WIDTH-1];
                    w_sb_nxt    = divisor[WIDTH-1];
                    w_dz_c_nxt  = (divisor == '0);
                    w_ov_c_nxt  = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StCalc;
                end
            end
            StCalc: begin
                w_pr_nxt  = w_ge ? w_diff : w_shifted[WIDTH-1:0];
                w_dvd_nxt = {r_dvd[WIDTH-2:0], w_ge};
                w_cnt_nxt = r_cnt + CntW'(1);
                if (w_last) begin
                    w_state_nxt = StFix;
                end
            end
            StFix: begin
                if (r_dz_c) begin
                    w_quot_nxt = '1;
                    w_rem_nxt  = r_a;
                end else if (r_ov_c) begin
                    w_quot_nxt = {1'b1, {(WIDTH-1){1'b0}}};
                    w_rem_nxt  = '0;
                end else begin
                    w_quot_nxt = w_q_signed;
                    w_rem_nxt  = w_r_signed;
                end
                w_dz_nxt    = r_dz_c;
                w_ov_nxt    = r_ov_c && !r_dz_c;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
            r_ov    <= 1'b0;
            r_pr    <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_a     <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dz_c  <= 1'b0;
            r_ov_c  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_quot  <= w_quot_nxt;
            r_rem   <= w_rem_nxt;
            r_dz    <= w_dz_nxt;
            r_ov    <= w_ov_nxt;
            r_pr    <= w_pr_nxt;
            r_dvd   <= w_dvd_nxt;
            r_dvs   <= w_dvs_nxt;
            r_a     <= w_a_nxt;
            r_sa    <= w_sa_nxt;
            r_sb    <= w_sb_nxt;
            r_dz_c  <= w_dz_c_nxt;
            r_ov_c  <= w_ov_c_nxt;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;
    assign overflow    = r_ov;

endmodule

// File: tb/tb_seq_signed_div.sv
// Self-checking bench for seq_signed_div: scoreboard of expected results, one task per scenario.
`timescale 1ns/1ps
module tb_seq_signed_div;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero, overflow;
    logic [W-1:0] quotient, remainder;

    seq_signed_div #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } vec_t;

    typedef logic [2*W+1:0] res_t;  // {q, r, dz, ov}

    res_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    vec_t tv [9] = '{
        '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0},  //  100 /  7
        '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0},  // -100 /  7
        '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0},  //  100 / -7
        '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0},  // -100 / -7
        '{8'h06, 8'h07, 8'h00, 8'h06, 1'b0, 1'b0},  //    6 /  7
        '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0},  // -128 /  1
        '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1},  // -128 / -1
        '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0},  //    5 /  0
        '{8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1'b0}   // -128 /  0
    };

    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        int   ai, bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        v.a = a;
        v.b = b;
        v.dz = 1'b0;
        v.ov = 1'b0;
        if (bi == 0) begin
            v.q = '1;
            v.r = a;
            v.dz = 1'b1;
        end else if (ai == -128 && bi == -1) begin
            v.q = 8'h80;
            v.r = '0;
            v.ov = 1'b1;
        end else begin
            v.q = W'(ai / bi);
            v.r = W'(ai % bi);
        end
        return v;
    endfunction

    task automatic start_op(input vec_t v);
        @(negedge clk);
        dividend = v.a;
        divisor  = v.b;
        start    = 1'b1;
        sb.push_back({v.q, v.r, v.dz, v.ov});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts falling edges until done; lat=-1 if the budget runs out.
    task automatic wait_done(input int budget, output int lat, output logic busy_bad);
        lat = -1;
        busy_bad = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                if (busy !== 1'b0) busy_bad = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_values: got %h want 0",
                     {busy, done, quotient, remainder, div_by_zero, overflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: got busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_basic();
        int   lat;
        logic bb;
        res_t e;
        start_op(tv[0]);
        wait_done(30, lat, bb);
        e = sb.pop_front();
        n_vec++;
        if (lat !== 10) begin
            n_err++;
            $display("FAIL basic_latency: got %0d want 10", lat);
        end
        n_vec++;
        if (bb !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy: busy profile wrong, got flag %b want 0", bb);
        end
        n_vec++;
        if ({quotient, remainder, div_by_zero, overflow} !== e) begin
            n_err++;
            $display("FAIL basic_result: got %h want %h",
                     {quotient, remainder, div_by_zero, overflow}, e);
        end
        @(negedge clk);
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_done_pulse: got busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_signs();
        int   lat;
        logic bb;
        res_t e;
        for (int i = 1; i <= 5; i++) begin
            start_op(tv[i]);
            wait_done(30, lat, bb);
            e = sb.pop_front();
            n_vec++;
            if (lat !== 10 || bb !== 1'b0) begin
                n_err++;
                $display("FAIL signs_timing[%0d]: got lat=%0d busy_bad=%b want 10/0", i, lat, bb);
            end
            n_vec++;
            if ({quotient, remainder, div_by_zero, overflow} !== e) begin
                n_err++;
                $display("FAIL signs_result[%0d]: got %h want %h", i,
                         {quotient, remainder, div_by_zero, overflow}, e);
            end
        end
    endtask

    task automatic test_boundaries();
        int   lat;
        logic bb;
        res_t e;
        for (int i = 6; i <= 8; i++) begin
            start_op(tv[i]);
            wait_done(30, lat, bb);
            e = sb.pop_front();
            n_vec++;
            if (lat !== 10 || bb !== 1'b0) begin
                n_err++;
                $display("FAIL bound_timing[%0d]: got lat=%0d busy_bad=%b want 10/0", i, lat, bb);
            end
            n_vec++;
            if ({quotient, remainder, div_by_zero, overflow} !== e) begin
                n_err++;
                $display("FAIL bound_result[%0d]: got %h want %h", i,
                         {quotient, remainder, div_by_zero, overflow}, e);
            end
        end
    endtask

    task automatic test_handshake();
        int   lat;
        int   extra;
        logic bb;
        res_t e;
        res_t held;
        held = {tv[8].q, tv[8].r, tv[8].dz, tv[8].ov};
        start_op(tv[1]);
        fork
            wait_done(30, lat, bb);
            begin
                repeat (3) @(negedge clk);
                dividend = 8'd9;
                divisor  = 8'd3;
                start    = 1'b1;
                @(negedge clk);
                start    = 1'b0;
                dividend = 8'h11;
                divisor  = 8'h05;
                n_vec++;
                if ({quotient, remainder, div_by_zero, overflow} !== held) begin
                    n_err++;
                    $display("FAIL hold_during_calc: got %h want %h",
                             {quotient, remainder, div_by_zero, overflow}, held);
                end
            end
        join
        e = sb.pop_front();
        n_vec++;
        if (lat !== 10 || bb !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_timing: got lat=%0d busy_bad=%b want 10/0", lat, bb);
        end
        n_vec++;
        if ({quotient, remainder, div_by_zero, overflow} !== e) begin
            n_err++;
            $display("FAIL ignore_result: got %h want %h",
                     {quotient, remainder, div_by_zero, overflow}, e);
        end
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL ignored_start_ran: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int   lat1, lat2;
        logic bb1, bb2;
        res_t e;
        vec_t v2;
        v2 = '{8'h4D, 8'hFB, 8'hF1, 8'h02, 1'b0, 1'b0};  // 77 / -5
        @(negedge clk);
        dividend = tv[2].a;
        divisor  = tv[2].b;
        start    = 1'b1;
        sb.push_back({tv[2].q, tv[2].r, tv[2].dz, tv[2].ov});
        @(posedge clk);
        #1;
        fork
            wait_done(30, lat1, bb1);
            begin
                repeat (3) @(negedge clk);
                dividend = v2.a;
                divisor  = v2.b;
                sb.push_back({v2.q, v2.r, v2.dz, v2.ov});
            end
        join
        e = sb.pop_front();
        n_vec++;
        if (lat1 !== 10 || bb1 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first_timing: got lat=%0d busy_bad=%b want 10/0", lat1, bb1);
        end
        n_vec++;
        if ({quotient, remainder, div_by_zero, overflow} !== e) begin
            n_err++;
            $display("FAIL b2b_first_result: got %h want %h",
                     {quotient, remainder, div_by_zero, overflow}, e);
        end
        fork
            wait_done(30, lat2, bb2);
            begin
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        e = sb.pop_front();
        n_vec++;
        if (lat2 !== 10 || bb2 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_timing: got lat=%0d busy_bad=%b want 10/0", lat2, bb2);
        end
        n_vec++;
        if ({quotient, remainder, div_by_zero, overflow} !== e) begin
            n_err++;
            $display("FAIL b2b_second_result: got %h want %h",
                     {quotient, remainder, div_by_zero, overflow}, e);
        end
    endtask

    task automatic test_reset_midop();
        int   lat;
        int   extra;
        logic bb;
        res_t e;
        vec_t v;
        start_op(model(8'd127, 8'd3));
        repeat (3) @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        n_vec++;
        if ({busy, done, quotient, remainder} !== '0) begin
            n_err++;
            $display("FAIL midop_reset: got %h want 0", {busy, done, quotient, remainder});
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL midop_no_done: got %0d active cycles want 0", extra);
        end
        v = '{8'd50, 8'hFD, 8'hF0, 8'h02, 1'b0, 1'b0};  // 50 / -3
        start_op(v);
        wait_done(30, lat, bb);
        e = sb.pop_front();
        n_vec++;
        if (lat !== 10 || {quotient, remainder, div_by_zero, overflow} !== e) begin
            n_err++;
            $display("FAIL midop_after: got lat=%0d res=%h want 10 %h", lat,
                     {quotient, remainder, div_by_zero, overflow}, e);
        end
    endtask

    task automatic test_random();
        int           lat, qi, ri, ai, bi, correct;
        logic         bb, inv_ok;
        logic [W-1:0] a, b;
        res_t         e;
        correct = 0;
        for (int i = 0; i < 200; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            while (b == '0 || (a == 8'h80 && b == 8'hFF)) b = W'($urandom);
            start_op(model(a, b));
            wait_done(30, lat, bb);
            e  = sb.pop_front();
            ai = int'($signed(a));
            bi = int'($signed(b));
            qi = int'($signed(quotient));
            ri = int'($signed(remainder));
            inv_ok = (qi * bi + ri == ai) && ((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi))
                     && (ri == 0 || ((ri < 0) == (ai < 0)));
            n_vec++;
            if (lat !== 10) begin
                n_err++;
                $display("FAIL rand_latency[%0d]: got %0d want 10", i, lat);
            end
            n_vec++;
            if ({quotient, remainder, div_by_zero, overflow} !== e) begin
                n_err++;
                $display("FAIL rand_result[%0d] %0d/%0d: got %h want %h", i, ai, bi,
                         {quotient, remainder, div_by_zero, overflow}, e);
            end
            n_vec++;
            if (inv_ok !== 1'b1) begin
                n_err++;
                $display("FAIL rand_invariant[%0d] %0d/%0d: got q=%0d r=%0d want q*d+r==n",
                         i, ai, bi, qi, ri);
            end else if (lat == 10 && {quotient, remainder, div_by_zero, overflow} === e) begin
                correct++;
            end
        end
        $display("correct total: %0d / 200", correct);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_boundaries();
        test_handshake();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_signed_div.md
Name: seq_signed_div

Overview:
- Multi-cycle signed integer divider: the inverse operation of the team's sign-extended combinational multiplier.
- Computes quotient and remainder of two two's-complement operands using one restoring-division step per clock.
- Operands are accepted through a start/busy/done handshake.
- Used alongside the multiplier in the arithmetic lab datapath; results satisfy quotient*divisor + remainder == dividend, checkable with the existing multiplier.

Parameters:
WIDTH, 8, bit width of dividend, divisor, quotient and remainder (two's complement)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only while busy=0
dividend  input  WIDTH  signed dividend, captured on accepted start
divisor  input  WIDTH  signed divisor, captured on accepted start
busy  output  1  high from the accepting edge until the result edge
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  WIDTH  signed quotient, truncated toward zero
remainder  output  WIDTH  signed remainder, same sign as dividend (or zero)
div_by_zero  output  1  divisor was zero; valid with done, held until next done
overflow  output  1  most-negative / -1 case; valid with done, held until next done

Behaviour:
- Clock and reset:
  - Single clock domain clk. rst_n is asynchronous, active-low.
  - On reset: state=IDLE; busy, done, quotient, remainder, div_by_zero and overflow are all 0; iteration counter is 0.
- FSM states: IDLE, CALC, FIX.
  - IDLE: at posedge with start=1, capture |dividend| and |divisor| (WIDTH+1-bit internal magnitudes, so -2^(WIDTH-1) is representable), capture both sign bits and the zero-divisor status. Set busy=1, cnt=0, state=CALC.
  - CALC: each edge, shift the partial remainder left one bit, bringing in the next dividend MSB, then trial-subtract the divisor magnitude. If the difference is non-negative, keep it and set quotient bit 1; otherwise restore and set quotient bit 0. cnt increments. After the WIDTH-th step, state=FIX.
  - FIX: apply signs. Quotient is negated if the operand signs differ; remainder is negated if the dividend is negative. Register quotient, remainder and flags. Set done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency is fixed and data-independent, including the error cases:
  - Start accepted at edge k; done is high in the cycle after edge k+WIDTH+1 (WIDTH+2 edges; 10 for WIDTH=8).
- Next start:
  - start is accepted in the cycle in which done is high (busy=0 then). This gives a back-to-back throughput of one result per WIDTH+2 cycles.
- start while busy=1 is ignored. Operand inputs may change freely while busy; the captured copies are used.
- Outputs quotient, remainder and the flags hold their last values until the next FIX edge. They do not change during CALC.
- Divide by zero (divisor==0):
  - quotient = all ones (-1), remainder = dividend, div_by_zero=1, overflow=0.
- Overflow (dividend = -2^(WIDTH-1) and divisor = -1):
  - quotient = -2^(WIDTH-1) (wrapped), remainder=0, overflow=1, div_by_zero=0.
- Otherwise both flags are 0 at done.
- Reset asserted mid-operation: immediate return to the reset values. No done pulse is produced for the aborted operation.
- Arithmetic invariant for every non-flagged result: quotient*divisor + remainder == dividend, and |remainder| < |divisor|.

Test Plan:
1. rst_n=0 then 1; start=1 with 100 / 7 at edge k -> busy=1 for edges k..k+9; done=1 exactly in the cycle after edge k+9; quotient=14, remainder=2, flags 0.
2. Sign combinations: -100/7 -> q=-14 r=-2; 100/-7 -> q=-14 r=2; -100/-7 -> q=14 r=-2; 6/7 -> q=0 r=6; -128/1 -> q=-128 r=0.
3. Boundaries: -128/-1 -> q=-128 r=0 overflow=1; 5/0 -> q=-1 r=5 div_by_zero=1; -128/0 -> q=-1 r=-128 div_by_zero=1; latency still 10 cycles in each case.
4. Handshake: start pulsed again at k+3 with different operands -> ignored, first result unchanged. Operands changed during CALC -> no effect. start held high through done -> next operation accepted in the done cycle, second done exactly 10 cycles later.
5. Reset mid-operation: rst_n low at k+4 -> busy, done, quotient and remainder read 0 immediately. After release there is no done until a new start; a new 50/-3 then gives q=-16 r=2.
6. Randomised sweep: 200 random signed pairs with divisor nonzero and not the overflow case -> every result satisfies q*divisor + r == dividend, |r| < |divisor|, sign(r) matches the dividend. The bench counts passes and prints a total, e.g. "correct total: 200 / 200".
